mem_data_bus: RTL and testbench
===============================

// Module: mem_data_bus
// PURPOSE
//  Parametrised data memory for the MIPS datapath MEM stage; successor to the single-cycle word memory.
//  Adds byte/halfword/word access with sign/zero-extended loads and configurable wait-state latency.
//  Adds a ready/done handshake and fault reporting for misaligned or out-of-range accesses.
//  Sits between the MEM-stage address/data registers and the write-back mux.
// PARAMETERS
//  DEPTH    256  number of 32-bit words; legal byte addresses 0 .. 4*DEPTH-1
//  LATENCY  1    wait states between accept and access, range 0..7
// PORTS
//  clk                 in   1   rising-edge clock
//  rst                 in   1   synchronous, active-high reset
//  addr                in   32  byte address
//  mem_read_control    in   1   load request
//  write_data_control  in   1   store request
//  size                in   2   00 byte, 01 halfword, 10 word, 11 reserved (faults)
//  sign_ext            in   1   1 = sign-extend byte/half loads, 0 = zero-extend
//  wdata               in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  rdata               out  32  load result, right-aligned and extended
//  ready               out  1   1 = idle; a request is accepted at this edge
//  done                out  1   1-cycle pulse on access completion
//  fault               out  1   valid with done; 1 = access rejected
// BEHAVIOUR
//  Reset values: rdata=0, ready=1, done=0, fault=0, state=IDLE. Memory contents are not affected by rst and are zero at time 0.
//  States: IDLE -> WAIT -> DONE -> IDLE.
//  - IDLE: ready=1. At an edge where rd|wr=1, latch addr/size/sign_ext/wdata/op and load cnt=LATENCY.
//    Go to WAIT, or directly to DONE if LATENCY=0.
//  - WAIT: cnt decrements each cycle. Go to DONE on the edge where cnt==1.
//  - DONE: done=1 and ready=0 for exactly one cycle, then return to IDLE.
//  - The access (memory write, or rdata update) commits on the edge entering DONE.
//  Timing: done rises LATENCY+1 cycles after the accepting edge; ready is low from the accept until DONE exits.
//  Back-to-back requests: throughput is one access per LATENCY+2 cycles.
//  Requests while ready=0 are ignored, not queued.
//  Both rd and wr asserted: treated as a fault, no access.
//  Byte order: little-endian. Byte k of a word occupies bits [8k+7:8k].
//  Stores write only the addressed lanes: byte = 1 lane, half = lanes {0,1} or {2,3}, word = all 4.
//  Loads select the addressed lane(s) and extend to 32 bits per sign_ext. Word loads ignore sign_ext.
//  fault=1 when any of these hold:
//    - half with addr[0]=1
//    - word with addr[1:0]!=0
//    - size=11
//    - addr[31:2] >= DEPTH
//    - rd and wr both asserted
//  A faulting access still takes the full latency and pulses done with fault=1.
//  A faulting access leaves memory unchanged, and rdata holds its previous value.
//  rdata changes only on a successful load commit; it holds between loads and through stores.
//  rst asserted in any state: return to IDLE next edge with reset output values.
//  rst asserted on the edge that would commit: the commit is suppressed (no partial write).
//  rst overrides any simultaneous request.
// TESTING
//  1. LATENCY=1: word store 0x000877F8 @0x8, then word load @0x8
//     -> each done at accept+2; rdata=0x000877F8, fault=0.
//  2. Byte store 0x80 @0x9; lb (sign_ext=1) @0x9 -> rdata=0xFFFFFF80;
//     lbu @0x9 -> 0x00000080; word load @0x8 -> 0x000880F8.
//  3. Half store 0xBEEF @0xA; lh @0xA -> 0xFFFFBEEF; word load @0x8 -> 0xBEEF80F8.
//     Word load @0x6 -> fault=1, rdata still 0xBEEF80F8.
//  4. Word store @0x400 (DEPTH=256) and load with size=11
//     -> fault=1 on both; word load @0x0 returns the unchanged 0x00000000.
//  5. LATENCY=3: store 0x12345678 @0x10; assert rst for 1 cycle during WAIT
//     -> next cycle ready=1, done=0; load @0x10 returns 0x00000000.
//     A request pulsed during WAIT is dropped (no extra done).
//  6. LATENCY=0: load accepted at edge N -> done=1 in cycle N+1, ready=1 again in cycle N+2.

Source files
------------

// File: rtl/mem_data_bus.sv
// MEM-stage data memory with byte/half/word access,
// programmable wait states and a ready/done/fault handshake.
module mem_data_bus #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        mem_read_control,
  input  logic        write_data_control,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        done,
  output logic        fault
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [2:0]  cnt;
  logic [31:0] a_q;
  logic [31:0] wd_q;
  logic [1:0]  sz_q;
  logic        sx_q;
  logic        rd_q;
  logic        wr_q;
  logic        fault_q;

  logic [31:0] mem [DEPTH] = '{default: '0};

  logic        req;
  logic        accept;
  logic        enter_done;
  logic [31:0] a_c;
  logic [31:0] wd_c;
  logic [1:0]  sz_c;
  logic        sx_c;
  logic        rd_c;
  logic        wr_c;
  logic        fault_c;
  logic [AW-1:0] idx;
  logic [31:0] word;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] wlane;
  logic [3:0]  be;

  assign req    = mem_read_control | write_data_control;
  assign accept = (state == IDLE) & req;

  // With zero wait states the commit happens on the accepting
  // edge, before the request is latched, so use the live inputs.
  assign a_c  = (state == IDLE) ? addr : a_q;
  assign wd_c = (state == IDLE) ? wdata : wd_q;
  assign sz_c = (state == IDLE) ? size : sz_q;
  assign sx_c = (state == IDLE) ? sign_ext : sx_q;
  assign rd_c = (state == IDLE) ? mem_read_control : rd_q;
  assign wr_c = (state == IDLE) ? write_data_control : wr_q;

  assign enter_done = (state_nx == DONE) & (state != DONE);

  assign fault_c = (rd_c & wr_c)
                 | (sz_c == 2'b11)
                 | ((sz_c == 2'b01) & a_c[0])
                 | ((sz_c == 2'b10) & (a_c[1:0] != 2'b00))
                 | (a_c[31:2] >= DEPTH_W);

  assign idx     = a_c[AW+1:2];
  assign word    = mem[idx];
  assign shifted = word >> {a_c[1:0], 3'b000};

  // Right-align the addressed lanes and extend to 32 bits.
  always_comb begin
    load_val = word;
    unique case (1'b1)
      (sz_c == 2'b00):
        load_val = {{24{sx_c & shifted[7]}}, shifted[7:0]};
      (sz_c == 2'b01):
        load_val = {{16{sx_c & shifted[15]}}, shifted[15:0]};
      default:
        load_val = word;
    endcase
  end

  // Replicate store data across lanes and pick the byte enables.
  always_comb begin
    wlane = wd_c;
    be    = 4'b0000;
    unique case (1'b1)
      (sz_c == 2'b00): begin
        wlane = {4{wd_c[7:0]}};
        be    = 4'b0001 << a_c[1:0];
      end
      (sz_c == 2'b01): begin
        wlane = {2{wd_c[15:0]}};
        be    = a_c[1] ? 4'b1100 : 4'b0011;
      end
      (sz_c == 2'b10): begin
        wlane = wd_c;
        be    = 4'b1111;
      end
      default: begin
        wlane = wd_c;
        be    = 4'b0000;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req) state_nx = (LATENCY == 0) ? DONE : WAIT;
      WAIT: if (cnt == 3'd1) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    ready = (state == IDLE);
    done  = (state == DONE);
    fault = (state == DONE) & fault_q;
  end

  // Wait counter, load result and fault flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 3'd0;
      rdata   <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      if (accept)              cnt <= 3'(LATENCY);
      else if (state == WAIT)  cnt <= cnt - 3'd1;
      if (enter_done) begin
        fault_q <= fault_c;
        if (rd_c & ~fault_c) rdata <= load_val;
      end
    end
  end

  // Request capture at the accepting edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= addr;
      wd_q <= wdata;
      sz_q <= size;
      sx_q <= sign_ext;
      rd_q <= mem_read_control;
      wr_q <= write_data_control;
    end
  end

  // Lane-masked store; reset on the commit edge cancels it.
  always_ff @(posedge clk) begin
    if (!rst && enter_done && wr_c && !fault_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_data_bus.sv
// Bench for mem_data_bus: three instances at LATENCY 1, 3, 0
// driven with scoreboarded access sequences.
module tb_mem_data_bus;

  typedef struct {
    logic        r;
    logic        w;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] er;
    logic        ef;
  } op_t;

  logic        clk = 1'b0;
  logic [2:0]  rst_v = 3'b111;
  logic [2:0]  rd_v = '0;
  logic [2:0]  wr_v = '0;
  logic [2:0]  sx_v = '0;
  logic [1:0]  sz_v [3];
  logic [31:0] addr_v [3];
  logic [31:0] wd_v [3];
  logic [31:0] rdata_v [3];
  logic [2:0]  ready_v;
  logic [2:0]  done_v;
  logic [2:0]  fault_v;

  int checks = 0;
  int errors = 0;
  op_t sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_data_bus #(
      .DEPTH(256),
      .LATENCY((g == 0) ? 1 : (g == 1) ? 3 : 0)
    ) u_dut (
      .clk(clk),
      .rst(rst_v[g]),
      .addr(addr_v[g]),
      .mem_read_control(rd_v[g]),
      .write_data_control(wr_v[g]),
      .size(sz_v[g]),
      .sign_ext(sx_v[g]),
      .wdata(wd_v[g]),
      .rdata(rdata_v[g]),
      .ready(ready_v[g]),
      .done(done_v[g]),
      .fault(fault_v[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 0;
  endfunction

  function automatic op_t mk(input logic r, input logic w,
                             input logic [1:0] sz, input logic sx,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] er, input logic ef);
    op_t o;
    o.r = r; o.w = w; o.sz = sz; o.sx = sx;
    o.a = a; o.d = d; o.er = er; o.ef = ef;
    return o;
  endfunction

  task automatic drive(input int k, input op_t o);
    rd_v[k]   = o.r;
    wr_v[k]   = o.w;
    sz_v[k]   = o.sz;
    sx_v[k]   = o.sx;
    addr_v[k] = o.a;
    wd_v[k]   = o.d;
  endtask

  task automatic release_req(input int k);
    rd_v[k] = 1'b0;
    wr_v[k] = 1'b0;
  endtask

  // One access: accept, wait for done (bounded), sample, return to idle.
  task automatic run(input int k, input op_t o,
                     output logic [31:0] got_rd, output logic got_f,
                     output int lat);
    @(negedge clk);
    drive(k, o);
    @(posedge clk); #1;
    release_req(k);
    lat = 0;
    while (!done_v[k] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    got_rd = rdata_v[k];
    got_f  = fault_v[k];
    if (!done_v[k]) lat = -1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdata_v[k] !== 32'd0 || ready_v[k] !== 1'b1 ||
          done_v[k] !== 1'b0 || fault_v[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d] got rd=%h rdy=%b dn=%b f=%b exp 0/1/0/0",
                 k, rdata_v[k], ready_v[k], done_v[k], fault_v[k]);
      end
    end
    @(negedge clk);
    rst_v = 3'b000;
  endtask

  task automatic test_word();
    op_t ops[$];
    op_t e;
    logic [31:0] rd;
    logic f;
    int lat;
    ops.push_back(mk(0, 1, 2'b10, 0, 32'h8, 32'h000877F8, 32'h0, 0));
    ops.push_back(mk(1, 0, 2'b10, 0, 32'h8, 32'h0, 32'h000877F8, 0));
    foreach (ops[i]) begin
      sb.push_back(ops[i]);
      run(0, ops[i], rd, f, lat);
      e = sb.pop_front();
      checks++;
      if (rd !== e.er) begin
        errors++;
        $display("FAIL word[%0d] rdata got %h exp %h", i, rd, e.er);
      end
      checks++;
      if (f !== e.ef) begin
        errors++;
        $display("FAIL word[%0d] fault got %b exp %b", i, f, e.ef);
      end
      checks++;
      if (lat !== lat_of(0)) begin
        errors++;
        $display("FAIL word[%0d] latency got %0d exp %0d", i, lat, lat_of(0));
      end
    end
  endtask

  task automatic test_byte();
    op_t ops[$];
    op_t e;
    logic [31:0] rd;
    logic f;
    int lat;
    ops.push_back(mk(0, 1, 2'b00, 0, 32'h9, 32'h80, 32'h000877F8, 0));
    ops.push_back(mk(1, 0, 2'b00, 1, 32'h9, 32'h0, 32'hFFFFFF80, 0));
    ops.push_back(mk(1, 0, 2'b00, 0, 32'h9, 32'h0, 32'h00000080, 0));
    ops.push_back(mk(1, 0, 2'b10, 0, 32'h8, 32'h0, 32'h000880F8, 0));
    foreach (ops[i]) begin
      sb.push_back(ops[i]);
      run(0, ops[i], rd, f, lat);
      e = sb.pop_front();
      checks++;
      if (rd !== e.er || f !== e.ef) begin
        errors++;
        $display("FAIL byte[%0d] got rd=%h f=%b exp rd=%h f=%b",
                 i, rd, f, e.er, e.ef);
      end
      checks++;
      if (lat !== lat_of(0)) begin
        errors++;
        $display("FAIL byte[%0d] latency got %0d exp %0d", i, lat, lat_of(0));
      end
    end
  endtask

  task automatic test_half();
    op_t ops[$];
    op_t e;
    logic [31:0] rd;
    logic f;
    int lat;
    ops.push_back(mk(0, 1, 2'b01, 0, 32'hA, 32'hBEEF, 32'h000880F8, 0));
    ops.push_back(mk(1, 0, 2'b01, 1, 32'hA, 32'h0, 32'hFFFFBEEF, 0));
    ops.push_back(mk(1, 0, 2'b01, 0, 32'hA, 32'h0, 32'h0000BEEF, 0));
    ops.push_back(mk(1, 0, 2'b00, 1, 32'hB, 32'h0, 32'hFFFFFFBE, 0));
    ops.push_back(mk(1, 0, 2'b01, 1, 32'h8, 32'h0, 32'hFFFF80F8, 0));
    ops.push_back(mk(1, 0, 2'b10, 1, 32'h8, 32'h0, 32'hBEEF80F8, 0));
    ops.push_back(mk(1, 0, 2'b10, 0, 32'h6, 32'h0, 32'hBEEF80F8, 1));
    ops.push_back(mk(1, 0, 2'b01, 0, 32'h9, 32'h0, 32'hBEEF80F8, 1));
    foreach (ops[i]) begin
      sb.push_back(ops[i]);
      run(0, ops[i], rd, f, lat);
      e = sb.pop_front();
      checks++;
      if (rd !== e.er || f !== e.ef) begin
        errors++;
        $display("FAIL half[%0d] got rd=%h f=%b exp rd=%h f=%b",
                 i, rd, f, e.er, e.ef);
      end
      checks++;
      if (lat !== lat_of(0)) begin
        errors++;
        $display("FAIL half[%0d] latency got %0d exp %0d", i, lat, lat_of(0));
      end
    end
  endtask

  task automatic test_fault();
    op_t ops[$];
    op_t e;
    logic [31:0] rd;
    logic f;
    int lat;
    ops.push_back(mk(0, 1, 2'b10, 0, 32'h400, 32'hDEADBEEF, 32'hBEEF80F8, 1));
    ops.push_back(mk(1, 0, 2'b11, 0, 32'h0, 32'h0, 32'hBEEF80F8, 1));
    ops.push_back(mk(1, 1, 2'b10, 0, 32'h0, 32'h11111111, 32'hBEEF80F8, 1));
    ops.push_back(mk(1, 0, 2'b10, 0, 32'h0, 32'h0, 32'h00000000, 0));
    ops.push_back(mk(0, 1, 2'b10, 0, 32'h3FC, 32'hCAFEF00D, 32'h0, 0));
    ops.push_back(mk(1, 0, 2'b10, 0, 32'h3FC, 32'h0, 32'hCAFEF00D, 0));
    ops.push_back(mk(1, 0, 2'b10, 0, 32'h0, 32'h0, 32'h00000000, 0));
    ops.push_back(mk(1, 0, 2'b10, 0, 32'h8, 32'h0, 32'hBEEF80F8, 0));
    foreach (ops[i]) begin
      sb.push_back(ops[i]);
      run(0, ops[i], rd, f, lat);
      e = sb.pop_front();
      checks++;
      if (rd !== e.er || f !== e.ef) begin
        errors++;
        $display("FAIL fault[%0d] got rd=%h f=%b exp rd=%h f=%b",
                 i, rd, f, e.er, e.ef);
      end
      checks++;
      if (lat !== lat_of(0)) begin
        errors++;
        $display("FAIL fault[%0d] latency got %0d exp %0d", i, lat, lat_of(0));
      end
    end
  endtask

  task automatic test_back_to_back();
    int first;
    int second;
    int n;
    first = -1;
    second = -1;
    n = 0;
    @(negedge clk);
    drive(0, mk(1, 0, 2'b10, 0, 32'h8, 32'h0, 32'h0, 0));
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (done_v[0]) begin
        n++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    release_req(0);
    for (int i = 0; i < 10 && !ready_v[0]; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL b2b done count got %0d exp 4", n);
    end
    checks++;
    if (second - first !== 3) begin
      errors++;
      $display("FAIL b2b period got %0d exp 3", second - first);
    end
    checks++;
    if (rdata_v[0] !== 32'hBEEF80F8) begin
      errors++;
      $display("FAIL b2b rdata got %h exp %h", rdata_v[0], 32'hBEEF80F8);
    end
  endtask

  task automatic test_latency3_reset();
    op_t e;
    logic [31:0] rd;
    logic f;
    int lat;
    int n;
    @(negedge clk);
    drive(1, mk(0, 1, 2'b10, 0, 32'h10, 32'h12345678, 32'h0, 0));
    @(posedge clk); #1;
    release_req(1);
    @(negedge clk);
    rst_v[1] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready_v[1] !== 1'b1 || done_v[1] !== 1'b0) begin
      errors++;
      $display("FAIL l3 mid-reset got rdy=%b dn=%b exp 1/0",
               ready_v[1], done_v[1]);
    end
    @(negedge clk);
    rst_v[1] = 1'b0;
    sb.push_back(mk(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0));
    run(1, sb[$], rd, f, lat);
    e = sb.pop_front();
    checks++;
    if (rd !== e.er || f !== e.ef || lat !== lat_of(1)) begin
      errors++;
      $display("FAIL l3 load got rd=%h f=%b lat=%0d exp rd=%h f=%b lat=%0d",
               rd, f, lat, e.er, e.ef, lat_of(1));
    end
    @(negedge clk);
    drive(1, mk(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0));
    @(posedge clk); #1;
    release_req(1);
    @(negedge clk);
    drive(1, mk(0, 1, 2'b10, 0, 32'h10, 32'hFFFFFFFF, 32'h0, 0));
    n = 0;
    @(posedge clk); #1;
    release_req(1);
    if (done_v[1]) n++;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done_v[1]) n++;
    end
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL l3 dropped-request done count got %0d exp 1", n);
    end
    sb.push_back(mk(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0));
    run(1, sb[$], rd, f, lat);
    e = sb.pop_front();
    checks++;
    if (rd !== e.er || f !== e.ef) begin
      errors++;
      $display("FAIL l3 after-drop got rd=%h f=%b exp rd=%h f=%b",
               rd, f, e.er, e.ef);
    end
  endtask

  task automatic test_latency0();
    op_t ops[$];
    op_t e;
    logic [31:0] rd;
    logic f;
    int lat;
    ops.push_back(mk(0, 1, 2'b10, 0, 32'h4, 32'hA5A5A5A5, 32'h0, 0));
    ops.push_back(mk(1, 0, 2'b10, 0, 32'h4, 32'h0, 32'hA5A5A5A5, 0));
    foreach (ops[i]) begin
      sb.push_back(ops[i]);
      run(2, ops[i], rd, f, lat);
      e = sb.pop_front();
      checks++;
      if (rd !== e.er || f !== e.ef || lat !== lat_of(2)) begin
        errors++;
        $display("FAIL l0[%0d] got rd=%h f=%b lat=%0d exp rd=%h f=%b lat=%0d",
                 i, rd, f, lat, e.er, e.ef, lat_of(2));
      end
    end
    @(negedge clk);
    drive(2, mk(1, 0, 2'b00, 0, 32'h4, 32'h0, 32'h0, 0));
    @(posedge clk); #1;
    release_req(2);
    checks++;
    if (done_v[2] !== 1'b1 || ready_v[2] !== 1'b0 ||
        rdata_v[2] !== 32'h000000A5) begin
      errors++;
      $display("FAIL l0 N+1 got dn=%b rdy=%b rd=%h exp 1/0/000000a5",
               done_v[2], ready_v[2], rdata_v[2]);
    end
    @(posedge clk); #1;
    checks++;
    if (done_v[2] !== 1'b0 || ready_v[2] !== 1'b1) begin
      errors++;
      $display("FAIL l0 N+2 got dn=%b rdy=%b exp 0/1", done_v[2], ready_v[2]);
    end
  endtask

  task automatic test_reset_commit();
    op_t e;
    logic [31:0] rd;
    logic f;
    int lat;
    @(negedge clk);
    drive(0, mk(0, 1, 2'b10, 0, 32'h20, 32'h00000055, 32'h0, 0));
    @(posedge clk); #1;
    release_req(0);
    @(negedge clk);
    rst_v[0] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done_v[0] !== 1'b0 || ready_v[0] !== 1'b1 || rdata_v[0] !== 32'd0) begin
      errors++;
      $display("FAIL commit-reset got dn=%b rdy=%b rd=%h exp 0/1/0",
               done_v[0], ready_v[0], rdata_v[0]);
    end
    @(negedge clk);
    rst_v[0] = 1'b0;
    sb.push_back(mk(1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h0, 0));
    run(0, sb[$], rd, f, lat);
    e = sb.pop_front();
    checks++;
    if (rd !== e.er || f !== e.ef) begin
      errors++;
      $display("FAIL commit-reset load got rd=%h f=%b exp rd=%h f=%b",
               rd, f, e.er, e.ef);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      sz_v[k]   = 2'b10;
      addr_v[k] = 32'd0;
      wd_v[k]   = 32'd0;
    end
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_fault();
    test_back_to_back();
    test_latency3_reset();
    test_latency0();
    test_reset_commit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
